// File: rtl/ysyx_22050854_mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package ysyx_22050854_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef struct packed {
        logic pos;
        logic dpos;
        logic neg;
        logic dneg;
    } booth_sel_t;

    localparam logic [1:0] MUL_SS = 2'b11;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_UU = 2'b00;

    localparam int WORD_DIGITS = 17;

endpackage

// File: rtl/ysyx_22050854_booth_pp.sv
// Single radix-4 Booth digit: decodes a 3-bit window and selects the partial product.
module ysyx_22050854_booth_pp
    import ysyx_22050854_mul_pkg::*;
#(
    parameter int W = 66
) (
    input  logic [2:0] digit,
    input  logic [W-1:0] x,
    output logic [W:0] pp,
    output logic cin
);

    booth_sel_t sel;

    always_comb begin
        sel = '0;
        case (digit)
            3'b001, 3'b010: sel.pos  = 1'b1;
            3'b011:         sel.dpos = 1'b1;
            3'b100:         sel.dneg = 1'b1;
            3'b101, 3'b110: sel.neg  = 1'b1;
            default:        sel = '0;
        endcase
    end

    // Negative selections use one's complement here; the +1 goes out as cin.
    always_comb begin
        pp = '0;
        if (sel.pos || sel.neg) begin
            pp = {x[W-1], x};
        end else if (sel.dpos || sel.dneg) begin
            pp = {x, 1'b0};
        end
        if (sel.neg || sel.dneg) begin
            pp = ~pp;
        end
    end

    assign cin = sel.neg | sel.dneg;

endmodule

// File: rtl/ysyx_22050854_booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one digit per cycle, valid/ready on both sides, flushable.
module ysyx_22050854_booth_mul_seq
    import ysyx_22050854_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic mul_valid,
    output logic mul_ready,
    input  logic mulw,
    input  logic [1:0] mul_signed,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic out_valid,
    input  logic out_ready,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int W     = XLEN + 2;
    localparam int AW    = 2 * W;
    localparam int CNT_W = $clog2(W / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(W / 2);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_DIGITS);

    state_t state, state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last;
    logic [AW-2:0] mcand;
    logic [AW-2:0] a_ext;
    logic [W:0] mplier;
    logic [W-1:0] b_ext;
    logic [AW-1:0] acc;
    logic [AW-1:0] pp;
    logic pp_cin;
    logic mulw_r;
    logic a_signed, b_signed;
    logic accept, step;
    logic unused_acc_top;

    assign a_signed = (mul_signed == MUL_SS) || (mul_signed == MUL_SU);
    assign b_signed = (mul_signed == MUL_SS);

    always_comb begin
        if (mulw) begin
            a_ext = {{(AW - 33){a_signed & multiplicand[31]}}, multiplicand[31:0]};
            b_ext = {{(W - 32){b_signed & multiplier[31]}}, multiplier[31:0]};
        end else begin
            a_ext = {{(AW - 1 - XLEN){a_signed & multiplicand[XLEN-1]}}, multiplicand};
            b_ext = {{(W - XLEN){b_signed & multiplier[XLEN-1]}}, multiplier};
        end
    end

    assign mul_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = mul_valid && (state == S_IDLE) && !flush;
    assign last      = mulw_r ? LAST_WORD : LAST_FULL;
    // Counter runs 0..N: N digit cycles followed by one cycle that only moves to DONE.
    assign step      = (state == S_BUSY) && (count != last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (mul_valid) state_next = S_BUSY;
                S_BUSY:  if (count == last) state_next = S_DONE;
                S_DONE:  if (out_ready) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    ysyx_22050854_booth_pp #(
        .W(AW - 1)
    ) u_pp (
        .digit(mplier[2:0]),
        .x    (mcand),
        .pp   (pp),
        .cin  (pp_cin)
    );

    // The multiplier carries an appended zero as b[-1], so the low three bits form the digit window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            mulw_r <= 1'b0;
        end else if (flush) begin
            count <= '0;
        end else if (accept) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= a_ext;
            mplier <= {b_ext, 1'b0};
            mulw_r <= mulw;
        end else if (step) begin
            count  <= count + CNT_W'(1);
            acc    <= acc + pp + {{(AW - 1){1'b0}}, pp_cin};
            mcand  <= mcand << 2;
            mplier <= mplier >> 2;
        end
    end

    always_comb begin
        if (mulw_r) begin
            result_lo = {{(XLEN - 32){acc[31]}}, acc[31:0]};
            result_hi = {{(XLEN - 32){acc[63]}}, acc[63:32]};
        end else begin
            result_lo = acc[XLEN-1:0];
            result_hi = acc[2*XLEN-1:XLEN];
        end
    end

    assign unused_acc_top = ^acc[AW-1:2*XLEN];

endmodule

// File: tb/tb_ysyx_22050854_booth_mul_seq.sv
// Directed self-checking bench for the sequential Booth multiplier (XLEN=64).
module tb_ysyx_22050854_booth_mul_seq;

    logic clk = 1'b0;
    logic rst_n, flush, mul_valid, mul_ready, mulw, out_valid, out_ready;
    logic [1:0] mul_signed;
    logic [63:0] multiplicand, multiplier, result_hi, result_lo;
    int tests = 0;
    int fails = 0;
    int lat;
    int seen;

    always #5 clk = ~clk;

    ysyx_22050854_booth_mul_seq #(.XLEN(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .mul_valid   (mul_valid),
        .mul_ready   (mul_ready),
        .mulw        (mulw),
        .mul_signed  (mul_signed),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_hi   (result_hi),
        .result_lo   (result_lo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the operand inputs after the accept edge, and count edges to out_valid.
    task automatic applyStimulus(input string tag, input logic w, input logic [1:0] s,
                                 input logic [63:0] a, input logic [63:0] b, output int cycles);
        @(negedge clk);
        mul_valid    = 1'b1;
        mulw         = w;
        mul_signed   = s;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        mul_valid    = 1'b0;
        multiplicand = 64'hA5A5_5A5A_C3C3_3C3C;
        multiplier   = 64'h1234_8765_FEDC_0123;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("ready_after_handshake", {63'd0, mul_ready}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        mul_valid = 1'b0;
        mulw = 1'b0;
        mul_signed = 2'b00;
        multiplicand = '0;
        multiplier = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset_mul_ready", {63'd0, mul_ready}, 64'd1);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_hi", result_hi, 64'd0);
        checkOutput("reset_lo", result_lo, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("ss_neg3x7", 1'b0, 2'b11, -64'sd3, 64'd7, lat);
        checkOutput("ss_neg3x7_lat", 64'(lat), 64'd34);
        checkOutput("ss_neg3x7_lo", result_lo, 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("ss_neg3x7_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("ss_neg3x7_busy_ready", {63'd0, mul_ready}, 64'd0);
        retire();

        applyStimulus("uu_max", 1'b0, 2'b00, '1, '1, lat);
        checkOutput("uu_max_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("uu_max_lo", result_lo, 64'h1);
        retire();

        applyStimulus("su_max", 1'b0, 2'b10, '1, '1, lat);
        checkOutput("su_max_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("su_max_lo", result_lo, 64'h1);
        retire();

        applyStimulus("ss_m1m1", 1'b0, 2'b11, '1, '1, lat);
        checkOutput("ss_m1m1_hi", result_hi, 64'h0);
        checkOutput("ss_m1m1_lo", result_lo, 64'h1);
        retire();

        applyStimulus("illegal01", 1'b0, 2'b01, '1, '1, lat);
        checkOutput("illegal01_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("illegal01_lo", result_lo, 64'h1);
        retire();

        applyStimulus("ss_minmin", 1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat);
        checkOutput("ss_minmin_hi", result_hi, 64'h4000_0000_0000_0000);
        checkOutput("ss_minmin_lo", result_lo, 64'h0);
        retire();

        applyStimulus("w_ss", 1'b1, 2'b11, 64'h0000_0000_8000_0000, 64'd3, lat);
        checkOutput("w_ss_lat", 64'(lat), 64'd18);
        checkOutput("w_ss_lo", result_lo, 64'hFFFF_FFFF_8000_0000);
        checkOutput("w_ss_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
        retire();

        applyStimulus("w_uu", 1'b1, 2'b00, 64'h7777_0000_FFFF_FFFF, 64'h1357_9BDF_FFFF_FFFF, lat);
        checkOutput("w_uu_lo", result_lo, 64'h1);
        checkOutput("w_uu_hi", result_hi, 64'hFFFF_FFFF_FFFF_FFFE);
        retire();

        // Flush alongside a request in IDLE must drop the request.
        @(negedge clk);
        mul_valid = 1'b1;
        flush = 1'b1;
        multiplicand = 64'd9;
        multiplier = 64'd9;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
        flush = 1'b0;
        checkOutput("flush_idle_ready", {63'd0, mul_ready}, 64'd1);

        // Flush in the middle of BUSY.
        @(negedge clk);
        mul_valid = 1'b1;
        mulw = 1'b0;
        mul_signed = 2'b11;
        multiplicand = 64'd123;
        multiplier = 64'd456;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy_ready", {63'd0, mul_ready}, 64'd1);
        checkOutput("flush_busy_valid", {63'd0, out_valid}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1;
        end
        checkOutput("flush_no_valid", 64'(seen), 64'd0);

        applyStimulus("uu_5x6", 1'b0, 2'b00, 64'd5, 64'd6, lat);
        checkOutput("uu_5x6_lat", 64'(lat), 64'd34);
        checkOutput("uu_5x6_lo", result_lo, 64'd30);
        checkOutput("uu_5x6_hi", result_hi, 64'd0);

        // Backpressure: DONE holds with frozen results.
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_ready", {63'd0, mul_ready}, 64'd0);
            checkOutput("bp_lo", result_lo, 64'd30);
        end
        retire();

        // Asynchronous reset mid-operation.
        @(negedge clk);
        mul_valid = 1'b1;
        mul_signed = 2'b11;
        multiplicand = -64'sd3;
        multiplier = 64'd7;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_mid_ready", {63'd0, mul_ready}, 64'd1);
        checkOutput("rst_mid_hi", result_hi, 64'd0);
        checkOutput("rst_mid_lo", result_lo, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("post_rst", 1'b0, 2'b00, 64'h1234_5678, 64'h10, lat);
        checkOutput("post_rst_lo", result_lo, 64'h1_2345_6780);
        checkOutput("post_rst_hi", result_hi, 64'd0);
        retire();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
